// File: rtl/sh_mac_pipe.sv
// sh_mac_pipe: SH-2 style multiply/accumulate unit with configurable execute latency and BUSY stall.
module sh_mac_pipe #(
  parameter int DW    = 32,
  parameter int LAT   = 2,
  parameter int SAT_W = 48
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CE_R,
  input  logic          RES_N,
  input  logic [DW-1:0] CBUS_A,
  input  logic [DW-1:0] CBUS_DI,
  output logic [DW-1:0] CBUS_DO,
  input  logic [1:0]    MAC_SEL,
  input  logic [3:0]    MAC_OP,
  input  logic          MAC_S,
  input  logic          MAC_WE,
  output logic          CBUS_BUSY
);
  localparam int HW = DW / 2;
  localparam int PW = 2 * DW;
  localparam logic [3:0] OP_MULL  = 4'b0001;
  localparam logic [3:0] OP_DMULU = 4'b0010;
  localparam logic [3:0] OP_DMULS = 4'b0011;
  localparam logic [3:0] OP_MULUW = 4'b0110;
  localparam logic [3:0] OP_MULSW = 4'b0111;
  localparam logic [3:0] OP_MACL  = 4'b1001;
  localparam logic [3:0] OP_MACW  = 4'b1011;
  localparam logic [3:0] OP_CLR   = 4'b1111;
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state, state_nx;
  logic [DW-1:0] mach, macl, ma, mb, lo_x, hi_x, wval, wb_h, wb_l;
  logic [HW-1:0] half;
  logic [3:0] op;
  logic sgn, sat;
  logic [1:0] cnt;
  logic wr, is_lds, is_clr, is_mulw, is_exe, start, done, wb;
  logic [PW-1:0] xa, xb, prod, acc, l_max;
  logic w_ovf, l_ovf;
  logic unused_ok;
  assign CBUS_BUSY = state == EXEC && MAC_SEL != 2'b00;
  assign CBUS_DO   = MAC_SEL[1] ? mach : macl;
  assign wr      = CE_R && RES_N && !CBUS_BUSY && MAC_WE && MAC_SEL != 2'b00;
  assign is_lds  = MAC_OP[2:0] == 3'b000;
  assign is_clr  = MAC_OP == OP_CLR;
  assign is_mulw = MAC_OP[3:1] == 3'b011;
  assign is_exe  = MAC_OP inside {OP_MULL, OP_DMULU, OP_DMULS, OP_MULUW, OP_MULSW, OP_MACL, OP_MACW};
  assign start   = wr && MAC_SEL[1] && is_exe;
  assign done    = state == EXEC && cnt == 2'd0;
  assign wb      = CE_R && RES_N && done;
  assign unused_ok = ^{CBUS_A[DW-1:2], CBUS_A[0]};
  // MAC.W picks the upper half when A[1]=0; MULx.W splits one word into both operands
  assign half = CBUS_A[1] ? CBUS_DI[HW-1:0] : CBUS_DI[DW-1:HW];
  assign wval = MAC_OP == OP_MACW ? {{(DW-HW){half[HW-1]}}, half} : CBUS_DI;
  assign lo_x = {{(DW-HW){MAC_OP[0] & CBUS_DI[HW-1]}}, CBUS_DI[HW-1:0]};
  assign hi_x = {{HW{MAC_OP[0] & CBUS_DI[DW-1]}}, CBUS_DI[DW-1:HW]};
  assign xa    = sgn ? {{DW{ma[DW-1]}}, ma} : {{DW{1'b0}}, ma};
  assign xb    = sgn ? {{DW{mb[DW-1]}}, mb} : {{DW{1'b0}}, mb};
  assign prod  = xa * xb;
  assign acc   = {mach, macl} + prod;
  assign w_ovf = !(&acc[PW-1:DW-1] || !(|acc[PW-1:DW-1]));
  assign l_ovf = !(&acc[PW-1:SAT_W-1] || !(|acc[PW-1:SAT_W-1]));
  assign l_max = {{(PW-SAT_W+1){1'b0}}, {(SAT_W-1){1'b1}}};
  always_comb begin
    {wb_h, wb_l} = {mach, macl};
    case (op)
      OP_MULL, OP_MULUW, OP_MULSW: wb_l = prod[DW-1:0];
      OP_DMULU, OP_DMULS: {wb_h, wb_l} = prod;
      OP_MACL: {wb_h, wb_l} = !(sat && l_ovf) ? acc : acc[PW-1] ? ~l_max : l_max;
      OP_MACW: begin
        wb_h = sat && w_ovf ? {{(DW-1){1'b0}}, 1'b1} : sat ? mach : acc[PW-1:DW];
        wb_l = !(sat && w_ovf) ? acc[DW-1:0] : acc[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (CE_R) state_nx = !RES_N ? IDLE : start ? EXEC : done ? IDLE : state;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      mach <= '0;
      macl <= '0;
      ma   <= '0;
      mb   <= '0;
      op   <= '0;
      sgn  <= 1'b0;
      sat  <= 1'b0;
      cnt  <= '0;
    end else if (CE_R) begin
      cnt <= !RES_N ? 2'd0 : start ? 2'(LAT - 1) : state == EXEC && cnt != 2'd0 ? cnt - 2'd1 : cnt;
      if (start) begin
        op  <= MAC_OP;
        sgn <= MAC_OP[0];
        sat <= MAC_S;
        mb  <= is_mulw ? hi_x : wval;
      end
      if (wr && MAC_SEL[0] && is_exe) ma <= wval;
      if (wr && MAC_SEL[1] && is_mulw) ma <= lo_x;
      if (wb) {mach, macl} <= {wb_h, wb_l};
      else if (wr && is_clr) {mach, macl} <= '0;
      else if (wr && is_lds) begin
        if (MAC_SEL[0]) macl <= CBUS_DI;
        if (MAC_SEL[1]) mach <= CBUS_DI;
      end
    end
endmodule
